// File: rtl/ycr1_icache_line_resp_if.sv
// Icache request/response channel, line-invalidate strobe and the Wishbone
// classic read port used for refills.
interface ycr1_icache_line_resp_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          flush;
    logic          icache_req;
    logic          icache_cmd;
    logic [1:0]    icache_width;
    logic [AW-1:0] icache_addr;
    logic          icache_req_ack;
    logic [DW-1:0] icache_rdata;
    logic [1:0]    icache_resp;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic [3:0]    wb_sel_o;
    logic [AW-1:0] wb_adr_o;
    logic [DW-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;

    // master: requester plus instruction memory; slave: the line responder
    modport master (
        output flush, icache_req, icache_cmd, icache_width, icache_addr,
        output wb_dat_i, wb_ack_i, wb_err_i,
        input  icache_req_ack, icache_rdata, icache_resp,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o
    );

    modport slave (
        input  flush, icache_req, icache_cmd, icache_width, icache_addr,
        input  wb_dat_i, wb_ack_i, wb_err_i,
        output icache_req_ack, icache_rdata, icache_resp,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o
    );
endinterface

// File: rtl/ycr1_icache_line_resp.sv
// Single-line instruction responder: hits served from a LINE_WORDS buffer,
// misses refilled sequentially over Wishbone classic reads.
module ycr1_icache_line_resp #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    ycr1_icache_line_resp_if.slave bus
);
    localparam int WW = $clog2(LINE_WORDS);
    localparam int TW = AW - WW - 2;

    localparam logic [1:0] RESP_NOTRDY = 2'b00;
    localparam logic [1:0] RESP_OK     = 2'b01;
    localparam logic [1:0] RESP_ER     = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RESP,
        ST_ERR
    } state_e;

    state_e        state_q, state_d;
    logic          valid_q, valid_d;
    logic          flush_pend_q, flush_pend_d;
    logic [WW-1:0] beat_q, beat_d;
    logic [TW-1:0] line_tag_q, line_tag_d;
    logic [TW-1:0] req_tag_q, req_tag_d;
    logic [WW-1:0] req_word_q, req_word_d;
    logic [DW-1:0] buf_q [LINE_WORDS];
    logic          buf_we;

    logic [TW-1:0] in_tag;
    logic [WW-1:0] in_word;
    logic          bad_req;
    logic          hit;
    logic          last_beat;

    always_comb begin
        in_tag    = bus.icache_addr[AW-1:WW+2];
        in_word   = bus.icache_addr[WW+1:2];
        bad_req   = bus.icache_cmd
                  || (bus.icache_width == 2'd3)
                  || ((bus.icache_width == 2'd1) && bus.icache_addr[0])
                  || ((bus.icache_width == 2'd2) && (bus.icache_addr[1:0] != 2'b00));
        // A flush arriving with the request invalidates the line before lookup.
        hit       = valid_q && !bus.flush && (in_tag == line_tag_q);
        last_beat = (beat_q == WW'(LINE_WORDS - 1));
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        beat_d       = beat_q;
        line_tag_d   = line_tag_q;
        req_tag_d    = req_tag_q;
        req_word_d   = req_word_q;
        buf_we       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.icache_req) begin
                    req_tag_d  = in_tag;
                    req_word_d = in_word;
                    if (bad_req) begin
                        state_d = ST_ERR;
                    end else if (hit) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d      = ST_FILL;
                        beat_d       = '0;
                        valid_d      = 1'b0;
                        flush_pend_d = 1'b0;
                    end
                end
            end
            ST_FILL: begin
                if (bus.flush) flush_pend_d = 1'b1;
                if (bus.wb_err_i) begin
                    valid_d = 1'b0;
                    state_d = ST_ERR;
                end else if (bus.wb_ack_i) begin
                    buf_we = 1'b1;
                    beat_d = beat_q + 1'b1;
                    if (last_beat) begin
                        line_tag_d = req_tag_q;
                        // A flush seen anywhere in the fill keeps the new line invalid.
                        valid_d    = !(flush_pend_q || bus.flush);
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RESP, ST_ERR: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase

        if (bus.flush && (state_q != ST_FILL)) valid_d = 1'b0;
    end

    always_comb begin
        bus.icache_req_ack = (state_q == ST_IDLE);
        bus.icache_resp    = RESP_NOTRDY;
        bus.icache_rdata   = '0;
        if (state_q == ST_RESP) begin
            bus.icache_resp  = RESP_OK;
            bus.icache_rdata = buf_q[req_word_q];
        end else if (state_q == ST_ERR) begin
            bus.icache_resp  = RESP_ER;
        end
        bus.wb_cyc_o = (state_q == ST_FILL);
        bus.wb_stb_o = (state_q == ST_FILL);
        bus.wb_we_o  = 1'b0;
        bus.wb_sel_o = 4'hF;
        bus.wb_adr_o = (state_q == ST_FILL) ? {req_tag_q, beat_q, 2'b00} : '0;
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            valid_q      <= 1'b0;
            flush_pend_q <= 1'b0;
            beat_q       <= '0;
            line_tag_q   <= '0;
            req_tag_q    <= '0;
            req_word_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            beat_q       <= beat_d;
            line_tag_q   <= line_tag_d;
            req_tag_q    <= req_tag_d;
            req_word_q   <= req_word_d;
        end
    end

    // NOTE: the line buffer has no reset; valid_q guards it, so it can map to plain storage.
    always_ff @(posedge clk) begin
        if (buf_we) buf_q[beat_q] <= bus.wb_dat_i;
    end
endmodule

// File: tb/tb_ycr1_icache_line_resp.sv
// Randomized scoreboard bench: stimulus predicts each response from a
// single-line cache model, a negedge monitor pops and compares.
module tb_ycr1_icache_line_resp;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 4;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          after_bus;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ycr1_icache_line_resp_if #(.AW(AW), .DW(DW)) bus ();

    ycr1_icache_line_resp #(.AW(AW), .DW(DW), .LINE_WORDS(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic        flush_a = 1'b0;
    logic        flush_b = 1'b0;
    logic        req     = 1'b0;
    logic        cmd     = 1'b0;
    logic [1:0]  width   = 2'd0;
    logic [31:0] addr    = 32'd0;
    logic        sl_ack  = 1'b0;
    logic        sl_err  = 1'b0;
    logic [31:0] sl_dat  = 32'd0;

    assign bus.flush        = flush_a | flush_b;
    assign bus.icache_req   = req;
    assign bus.icache_cmd   = cmd;
    assign bus.icache_width = width;
    assign bus.icache_addr  = addr;
    assign bus.wb_ack_i     = sl_ack;
    assign bus.wb_err_i     = sl_err;
    assign bus.wb_dat_i     = sl_dat;

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt  = 0;
    exp_t exp_q[$];

    // slave configuration written by the stimulus before each request
    logic [31:0] sl_base     = 32'd0;
    int          sl_waits    = 0;
    int          sl_err_beat = LW;
    bit          sl_flush_b1 = 1'b0;
    bit          expect_fill = 1'b0;
    int          term_cnt    = 0;
    int          sl_beat     = 0;
    int          wait_cnt    = 0;
    bit          flush_done  = 1'b0;
    logic        cyc_prev    = 1'b0;

    // reference line model
    bit          m_valid = 1'b0;
    logic [31:0] m_base  = 32'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_cnt);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if ((a & 32'hFFFF_FFF0) == 32'h0000_1000) return 32'hA0 + 32'(a[3:2]);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // monitor and Wishbone slave share one negedge process
    always @(negedge clk) begin
        exp_t e;
        if (bus.wb_cyc_o || (bus.icache_resp != 2'b00))
            check("req_ack_busy", 64'(bus.icache_req_ack), 64'd0);
        if (bus.icache_resp != 2'b00) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(bus.icache_resp), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp", 64'(bus.icache_resp), 64'(e.resp));
                check("rdata", 64'(bus.icache_rdata), 64'(e.rdata));
                check("resp_cycle", 64'(cyc_cnt), 64'(e.after_bus ? term_cnt + 1 : e.due));
            end
        end

        if (bus.wb_cyc_o && !cyc_prev) check("fill_expected", 64'(expect_fill), 64'd1);
        cyc_prev = bus.wb_cyc_o;
        flush_b  = 1'b0;
        sl_ack   = 1'b0;
        sl_err   = 1'b0;
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
            if ((sl_beat == 1) && sl_flush_b1 && !flush_done) begin
                flush_b    = 1'b1;
                flush_done = 1'b1;
            end
            if (wait_cnt < sl_waits) begin
                wait_cnt++;
            end else begin
                check("wb_adr", 64'(bus.wb_adr_o), 64'(sl_base + 32'(sl_beat) * 4));
                wait_cnt = 0;
                if (sl_beat == sl_err_beat) begin
                    sl_err   = 1'b1;
                    term_cnt = cyc_cnt;
                end else begin
                    sl_ack = 1'b1;
                    sl_dat = mem_word(bus.wb_adr_o);
                    if (sl_beat == LW - 1) term_cnt = cyc_cnt;
                end
                sl_beat++;
            end
        end else begin
            sl_beat    = 0;
            wait_cnt   = 0;
            flush_done = 1'b0;
        end
    end

    task automatic wait_idle();
        @(negedge clk);
        for (int i = 0; i < 50 && !bus.icache_req_ack; i++) @(negedge clk);
        check("req_ack_idle", 64'(bus.icache_req_ack), 64'd1);
    endtask

    // flush_mode: 0 none, 1 with the accept, 2 during refill beat 1
    task automatic issue(input bit c, input logic [1:0] w, input logic [31:0] a,
                         input int waits, input int err_beat, input int flush_mode);
        exp_t        e;
        bit          bad;
        bit          hit;
        logic [31:0] base;
        logic [31:0] wd;
        wait_idle();
        base = a & 32'hFFFF_FFF0;
        wd   = mem_word(base + 32'(a[3:2]) * 4);
        if (flush_mode == 1) m_valid = 1'b0;
        bad = c || (w == 2'd3) || ((w == 2'd1) && a[0]) || ((w == 2'd2) && (a[1:0] != 2'b00));
        hit = !bad && m_valid && (m_base == base);
        expect_fill = !bad && !hit;
        sl_base     = base;
        sl_waits    = waits;
        sl_err_beat = err_beat;
        sl_flush_b1 = (flush_mode == 2);
        if (bad) begin
            e = '{2'b10, 32'd0, 1'b0, cyc_cnt + 1};
        end else if (hit) begin
            e = '{2'b01, wd, 1'b0, cyc_cnt + 1};
        end else if (err_beat < LW) begin
            e = '{2'b10, 32'd0, 1'b1, 0};
            m_valid = 1'b0;
        end else begin
            e = '{2'b01, wd, 1'b1, 0};
            m_valid = (flush_mode != 2);
            m_base  = base;
        end
        exp_q.push_back(e);
        req = 1'b1; cmd = c; width = w; addr = a;
        flush_a = (flush_mode == 1);
        @(negedge clk);
        req = 1'b0; flush_a = 1'b0;
        cmd = 1'($urandom); width = 2'($urandom); addr = $urandom;
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            check("resp_timeout", 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
    endtask

    task automatic flush_idle();
        wait_idle();
        flush_a = 1'b1;
        @(negedge clk);
        flush_a = 1'b0;
        m_valid = 1'b0;
    endtask

    task automatic reset_mid_fill(input logic [31:0] a);
        wait_idle();
        expect_fill = 1'b1;
        sl_base = a & 32'hFFFF_FFF0; sl_waits = 2; sl_err_beat = LW; sl_flush_b1 = 1'b0;
        req = 1'b1; cmd = 1'b0; width = 2'd2; addr = a;
        @(negedge clk);
        req = 1'b0;
        for (int i = 0; i < 40 && bus.wb_adr_o != sl_base + 32'd4; i++) @(negedge clk);
        check("rst_reached_beat1", 64'(bus.wb_adr_o), 64'(sl_base + 32'd4));
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("rst_stb", 64'(bus.wb_stb_o), 64'd0);
        check("rst_resp", 64'(bus.icache_resp), 64'd0);
        check("rst_req_ack", 64'(bus.icache_req_ack), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] bases [5];
        logic [31:0] a;
        logic [1:0]  w;
        int          r;
        bases = '{32'h0000_1000, 32'h0000_2000, 32'h0000_3040, 32'hFFFF_FFF0, 32'h0000_0000};

        #12;
        check("reset_req_ack", 64'(bus.icache_req_ack), 64'd1);
        check("reset_resp", 64'(bus.icache_resp), 64'd0);
        check("reset_rdata", 64'(bus.icache_rdata), 64'd0);
        check("reset_cyc", 64'(bus.wb_cyc_o), 64'd0);
        check("reset_stb", 64'(bus.wb_stb_o), 64'd0);
        check("reset_adr", 64'(bus.wb_adr_o), 64'd0);
        check("reset_we", 64'(bus.wb_we_o), 64'd0);
        check("reset_sel", 64'(bus.wb_sel_o), 64'hF);
        @(negedge clk);
        rst = 1'b0;

        issue(1'b0, 2'd2, 32'h1008, 0, LW, 0);   // cold miss, zero-wait
        issue(1'b0, 2'd2, 32'h100C, 0, LW, 0);   // hit
        issue(1'b0, 2'd2, 32'h2000, 1, LW, 0);   // miss to a new line
        issue(1'b0, 2'd2, 32'h1000, 0, LW, 0);   // refill line 0x1000
        issue(1'b1, 2'd2, 32'h1000, 0, LW, 0);   // write -> error
        issue(1'b0, 2'd1, 32'h1001, 0, LW, 0);   // misaligned half -> error
        issue(1'b0, 2'd3, 32'h1004, 0, LW, 0);   // width 3 -> error
        issue(1'b0, 2'd0, 32'h1007, 0, LW, 0);   // byte still hits
        issue(1'b0, 2'd2, 32'h3000, 0, 2, 0);    // bus error on beat 2
        issue(1'b0, 2'd2, 32'h3000, 0, LW, 0);   // refills again from beat 0
        issue(1'b0, 2'd2, 32'h3004, 0, LW, 0);   // hit
        issue(1'b0, 2'd2, 32'h4008, 1, LW, 2);   // flush during beat 1
        issue(1'b0, 2'd2, 32'h4008, 0, LW, 0);   // re-read misses
        issue(1'b0, 2'd2, 32'h4008, 0, LW, 1);   // flush with accept -> miss
        issue(1'b0, 2'd1, 32'h400A, 0, LW, 0);   // hit
        flush_idle();
        issue(1'b0, 2'd2, 32'h4000, 0, LW, 0);   // idle flush -> miss
        reset_mid_fill(32'h5004);
        issue(1'b0, 2'd2, 32'h4000, 0, LW, 0);   // valid lost across reset -> miss

        for (int n = 0; n < 300; n++) begin
            a = bases[$urandom_range(0, 4)] | 32'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            w = (r < 2) ? 2'd0 : (r < 4) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            if ((w == 2'd2) && ($urandom_range(0, 3) != 0)) a[1:0] = 2'b00;
            if ((w == 2'd1) && ($urandom_range(0, 3) != 0)) a[0] = 1'b0;
            r = $urandom_range(0, 9);
            issue(($urandom_range(0, 9) == 0), w, a, $urandom_range(0, 2),
                  ($urandom_range(0, 7) == 0) ? $urandom_range(0, LW - 1) : LW,
                  (r == 0) ? 1 : (r == 1) ? 2 : 0);
            if ($urandom_range(0, 19) == 0) flush_idle();
        end

        repeat (4) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
